// File: rtl/div_sched.sv
// Two-requester front end for a shared divider. It arbitrates round-robin, launches
// one job at a time, short-circuits zero operands, times out a silent divider and returns tagged results.
module div_sched #(
  parameter int TIMEOUT = 15,
  parameter int W       = 5
) (
  input  logic         clk,
  input  logic         res,
  input  logic [1:0]   req,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  output logic [1:0]   gnt,
  output logic         div_load,
  output logic [W-1:0] div_a,
  output logic [W-1:0] div_b,
  input  logic         div_done,
  input  logic [W-1:0] div_q,
  input  logic [W-1:0] div_r,
  input  logic         div_err,
  output logic         rsp_vld,
  output logic         rsp_id,
  output logic [W-1:0] rsp_q,
  output logic [W-1:0] rsp_r,
  output logic         rsp_err,
  output logic [1:0]   dbg_state
);

  // Handshake: requester i holds req[i] until it sees gnt[i]. gnt is decoded in IDLE
  // in the same cycle that the operands are captured. rsp_vld is a one-cycle pulse with no backpressure.

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          last;
  logic          cur_id;
  logic          pick;
  logic [W-1:0]  sel_a;
  logic [W-1:0]  sel_b;

  // On contention the requester that was not served last goes next.
  always_comb begin
    pick = 1'b0;
    if (req == 2'b11) pick = ~last;
    else if (req[1])  pick = 1'b1;
    sel_a = pick ? a1 : a0;
    sel_b = pick ? b1 : b0;
    gnt   = 2'b00;
    if (state == IDLE && req != 2'b00 && !res) gnt = pick ? 2'b10 : 2'b01;
  end

  assign dbg_state = state;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state    <= IDLE;
      cnt      <= '0;
      last     <= 1'b1;
      cur_id   <= 1'b0;
      div_load <= 1'b0;
      div_a    <= '0;
      div_b    <= '0;
      rsp_vld  <= 1'b0;
      rsp_id   <= 1'b0;
      rsp_q    <= '0;
      rsp_r    <= '0;
      rsp_err  <= 1'b0;
    end else begin
      div_load <= 1'b0;
      rsp_vld  <= 1'b0;
      case (state)
        IDLE: begin
          if (req != 2'b00) begin
            cur_id <= pick;
            div_a  <= sel_a;
            div_b  <= sel_b;
            if (sel_a == '0 || sel_b == '0) begin
              state   <= RESP;
              rsp_vld <= 1'b1;
              rsp_id  <= pick;
              rsp_q   <= '0;
              rsp_r   <= '0;
              rsp_err <= 1'b1;
            end else begin
              state    <= LOAD;
              div_load <= 1'b1;
            end
          end
        end
        LOAD: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // A result arriving in the final wait cycle beats the timeout.
          if (div_done) begin
            state   <= RESP;
            rsp_vld <= 1'b1;
            rsp_id  <= cur_id;
            rsp_q   <= div_q;
            rsp_r   <= div_r;
            rsp_err <= div_err;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            state   <= RESP;
            rsp_vld <= 1'b1;
            rsp_id  <= cur_id;
            rsp_q   <= '0;
            rsp_r   <= '0;
            rsp_err <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          last  <= cur_id;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_sched.sv
// Bench for div_sched: a directed job table, reset/idle corner sequences, then random jobs
// scored against a transaction-level arbitration and latency model.
module tb_div_sched;

  localparam int W  = 5;
  localparam int TO = 15;

  logic         clk, res;
  logic [1:0]   req;
  logic [W-1:0] a0, b0, a1, b1;
  logic [1:0]   gnt;
  logic         div_load;
  logic [W-1:0] div_a, div_b;
  logic         div_done;
  logic [W-1:0] div_q, div_r;
  logic         div_err;
  logic         rsp_vld, rsp_id;
  logic [W-1:0] rsp_q, rsp_r;
  logic         rsp_err;
  logic [1:0]   dbg_state;

  div_sched #(.TIMEOUT(TO), .W(W)) dut (
    .clk(clk), .res(res), .req(req), .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt(gnt), .div_load(div_load), .div_a(div_a), .div_b(div_b),
    .div_done(div_done), .div_q(div_q), .div_r(div_r), .div_err(div_err),
    .rsp_vld(rsp_vld), .rsp_id(rsp_id), .rsp_q(rsp_q), .rsp_r(rsp_r),
    .rsp_err(rsp_err), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   rq;
    logic [W-1:0] a0, b0, a1, b1;
    int           lat;  // cycles from div_load to div_done, -1 = divider silent
    logic [W-1:0] dq, dr;
    logic         de;
    logic         id;   // expected grant / response id
    logic [W-1:0] eq, er;
    logic         ee;
    logic         ld;   // expect a div_load
    int           k;    // expected cycles from grant to rsp_vld
  } job_t;

  int total = 0;
  int bad   = 0;
  logic [2*W+1:0] exp_q[$];
  logic model_last;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic job_t mk(input logic [1:0] rq, input int x0, input int y0, input int x1,
                              input int y1, input int lat, input int dq, input int dr,
                              input logic de, input logic id, input int eq, input int er,
                              input logic ee, input logic ld, input int k);
    job_t j;
    j.rq = rq; j.a0 = W'(x0); j.b0 = W'(y0); j.a1 = W'(x1); j.b1 = W'(y1);
    j.lat = lat; j.dq = W'(dq); j.dr = W'(dr); j.de = de;
    j.id = id; j.eq = W'(eq); j.er = W'(er); j.ee = ee; j.ld = ld; j.k = k;
    return j;
  endfunction

  // Behavioural model: round-robin pick, zero short-circuit, timeout window.
  function automatic job_t model(input job_t j);
    job_t m;
    logic [W-1:0] a, b;
    m = j;
    m.id = (j.rq == 2'b11) ? ~model_last : j.rq[1];
    a = m.id ? j.a1 : j.a0;
    b = m.id ? j.b1 : j.b0;
    if (a == 0 || b == 0) begin
      m.ld = 1'b0; m.eq = '0; m.er = '0; m.ee = 1'b1; m.k = 1;
    end else if (j.lat >= 1 && j.lat <= TO) begin
      m.ld = 1'b1; m.eq = j.dq; m.er = j.dr; m.ee = j.de; m.k = j.lat + 2;
    end else begin
      m.ld = 1'b1; m.eq = '0; m.er = '0; m.ee = 1'b1; m.k = TO + 2;
    end
    return m;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  // driver: raise req, take the grant, act as the divider, score the response
  task automatic do_job(input job_t j);
    int n;
    bit got;
    logic [1:0] g;
    logic [2*W+1:0] e;
    req = j.rq; a0 = j.a0; b0 = j.b0; a1 = j.a1; b1 = j.b1; div_done = 1'b0;
    n = 0;
    @(negedge clk);
    while (gnt == 2'b00 && n < 20) begin
      @(negedge clk);
      n++;
    end
    g = gnt;
    chk("gnt", 32'(g), 32'(j.id ? 2'b10 : 2'b01));
    if (g == 2'b00) begin
      req = 2'b00;
      return;
    end
    exp_q.push_back({j.id, j.ee, j.eq, j.er});
    step();
    req = j.rq & ~g;
    got = 0;
    for (int k = 1; k <= TO + 4 && !got; k++) begin
      div_done = (k == j.lat + 1);
      div_q = j.dq; div_r = j.dr; div_err = j.de;
      @(negedge clk);
      chk("div_load", 32'(div_load), 32'(k == 1 && j.ld));
      chk("gnt_busy", 32'(gnt), 32'(0));
      if (k == 1 && j.ld) begin
        chk("div_a", 32'(div_a), 32'(j.id ? j.a1 : j.a0));
        chk("div_b", 32'(div_b), 32'(j.id ? j.b1 : j.b0));
      end
      if (rsp_vld) begin
        got = 1;
        chk("rsp_latency", 32'(k), 32'(j.k));
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("rsp_fields", 32'({rsp_id, rsp_err, rsp_q, rsp_r}), 32'(e));
        end
      end
      step();
    end
    div_done = 1'b0;
    if (!got) begin
      chk("rsp_timeout", 32'(0), 32'(1));
      exp_q.delete();
    end
    req = 2'b00;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_gnt"}, 32'(gnt), 32'(0));
    chk({tag, "_div_load"}, 32'(div_load), 32'(0));
    chk({tag, "_div_ab"}, 32'({div_a, div_b}), 32'(0));
    chk({tag, "_rsp"}, 32'({rsp_vld, rsp_id, rsp_err, rsp_q, rsp_r}), 32'(0));
    chk({tag, "_state"}, 32'(dbg_state), 32'(0));
  endtask

  job_t tbl[10];
  job_t rj;

  initial begin
    res = 1'b1; req = 2'b00; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    div_done = 1'b0; div_q = '0; div_r = '0; div_err = 1'b0;

    //           rq     a0 b0 a1 b1 lat dq dr de  id  eq er ee  ld  k
    tbl[0] = mk(2'b11, 13, 4, 20, 6, 6, 3, 1, 0, 0, 3, 1, 0, 1, 8);
    tbl[1] = mk(2'b11, 13, 4, 20, 6, 3, 3, 2, 0, 1, 3, 2, 0, 1, 5);
    tbl[2] = mk(2'b11, 13, 4, 20, 6, 1, 3, 1, 0, 0, 3, 1, 0, 1, 3);
    tbl[3] = mk(2'b10, 0, 0, 0, 7, 2, 9, 9, 0, 1, 0, 0, 1, 0, 1);
    tbl[4] = mk(2'b01, 9, 2, 0, 0, -1, 4, 1, 0, 0, 0, 0, 1, 1, 17);
    tbl[5] = mk(2'b10, 0, 0, 31, 5, 15, 6, 1, 0, 1, 6, 1, 0, 1, 17);
    tbl[6] = mk(2'b01, 7, 3, 0, 0, 2, 5, 4, 1, 0, 5, 4, 1, 1, 4);
    tbl[7] = mk(2'b01, 8, 3, 0, 0, 16, 2, 2, 0, 0, 0, 0, 1, 1, 17);
    tbl[8] = mk(2'b11, 0, 5, 10, 3, 4, 3, 1, 0, 1, 3, 1, 0, 1, 6);
    tbl[9] = mk(2'b11, 0, 5, 10, 3, 4, 3, 1, 0, 0, 0, 0, 1, 0, 1);

    #12;
    chk_reset_vals("reset");
    step();
    res = 1'b0;
    step();

    for (int i = 0; i < 10; i++) do_job(tbl[i]);

    // divider pulse while idle must be ignored
    div_done = 1'b1; div_q = 5'd7; div_r = 5'd3;
    @(negedge clk);
    step();
    div_done = 1'b0;
    @(negedge clk);
    chk("idle_done_vld", 32'(rsp_vld), 32'(0));
    chk("idle_done_state", 32'(dbg_state), 32'(0));
    step();
    @(negedge clk);
    chk("idle_done_vld2", 32'(rsp_vld), 32'(0));

    // reset in the middle of WAIT, then a late divider result
    step();
    req = 2'b01; a0 = 5'd13; b0 = 5'd4;
    @(negedge clk);
    chk("r_wait_gnt", 32'(gnt), 32'(2'b01));
    step();
    req = 2'b00;
    step();
    step();
    @(negedge clk);
    chk("r_wait_state", 32'(dbg_state), 32'(2));
    res = 1'b1;
    #1;
    chk_reset_vals("mid_wait_reset");
    step();
    res = 1'b0;
    div_done = 1'b1; div_q = 5'd3; div_r = 5'd1;
    @(negedge clk);
    chk("post_reset_vld", 32'(rsp_vld), 32'(0));
    step();
    div_done = 1'b0;
    @(negedge clk);
    chk("post_reset_vld2", 32'(rsp_vld), 32'(0));
    chk("post_reset_state", 32'(dbg_state), 32'(0));
    step();
    model_last = 1'b1;
    rj = mk(2'b11, 13, 4, 20, 6, 6, 3, 1, 0, 0, 0, 0, 0, 0, 0);
    rj = model(rj);
    do_job(rj);
    model_last = rj.id;

    // random jobs against the model
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] a, b;
      rj.rq = 2'($urandom_range(1, 3));
      rj.a0 = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 31));
      rj.b0 = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 31));
      rj.a1 = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 31));
      rj.b1 = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 31));
      rj.lat = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(1, TO + 2));
      rj = model(rj);
      a = rj.id ? rj.a1 : rj.a0;
      b = rj.id ? rj.b1 : rj.b0;
      rj.dq = (b != 0) ? a / b : '0;
      rj.dr = (b != 0) ? a % b : '0;
      rj.de = ($urandom_range(0, 7) == 0);
      rj = model(rj);
      do_job(rj);
      model_last = rj.id;
    end

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div_sched.md
DIV_SCHED -- requirements
Module: div_sched

Interface
REQ-001 Parameter TIMEOUT, default 15, max cycles waited in WAIT for div_done before abort.
REQ-002 Parameter W, default 5, operand/result width.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 res  input  1  reset, asynchronous, active-high.
REQ-005 req  input  2  per-requester request level, bit i = requester i.
REQ-006 a0, b0  input  W each  requester 0 dividend/divisor operands.
REQ-007 a1, b1  input  W each  requester 1 dividend/divisor operands.
REQ-008 gnt  output  2  one-hot one-cycle grant pulse; operands sampled that cycle.
REQ-009 div_load  output  1  one-cycle start pulse to shared divider.
REQ-010 div_a, div_b  output  W each  latched operands driven to divider, stable from div_load until return to IDLE.
REQ-011 div_done  input  1  divider result-valid pulse.
REQ-012 div_q, div_r  input  W each  divider quotient/remainder, valid with div_done.
REQ-013 div_err  input  1  divider error flag, valid with div_done.
REQ-014 rsp_vld  output  1  one-cycle response pulse.
REQ-015 rsp_id  output  1  index of requester owning the response.
REQ-016 rsp_q, rsp_r  output  W each  returned quotient/remainder, valid with rsp_vld.
REQ-017 rsp_err  output  1  error flag, valid with rsp_vld.

Function
REQ-018 FSM states IDLE, LOAD, WAIT, RESP; one job in flight at a time.
REQ-019 req sampled only in IDLE; requester holds req until its gnt bit; req dropped before grant yields no grant.
REQ-020 Arbitration round-robin: on both requests, grant the requester not granted last; after reset requester 0 has priority; single request granted immediately.
REQ-021 IDLE with any req: assert gnt bit, latch operands and id in same cycle (T); next state LOAD, or RESP if latched a or b is zero.
REQ-022 Zero operand short-circuit: no div_load issued; RESP at T+1 with rsp_err=1, rsp_q=rsp_r=0.
REQ-023 LOAD: div_load=1 for exactly one cycle (T+1); clear wait counter; next WAIT.
REQ-024 WAIT: counter increments per cycle; div_done=1 captures div_q, div_r, div_err and moves to RESP.
REQ-025 WAIT timeout: counter reaching TIMEOUT without div_done moves to RESP with rsp_err=1, rsp_q=rsp_r=0.
REQ-026 div_done coinciding with timeout cycle: div_done wins, result captured.
REQ-027 RESP: rsp_vld=1 one cycle with rsp_id, rsp_q, rsp_r, rsp_err; last-granted id updated; next IDLE.
REQ-028 rsp_q/rsp_r/rsp_err/rsp_id hold last value outside rsp_vld; consumers use only with rsp_vld.
REQ-029 div_done outside WAIT ignored, no state change.
REQ-030 New req arriving while busy is not granted until FSM returns to IDLE; earliest next gnt one cycle after rsp_vld.
REQ-031 Normal latency: gnt at T, div_load T+1, rsp_vld one cycle after div_done sampled.

Reset
REQ-032 res=1 forces IDLE immediately, regardless of state, including mid-WAIT.
REQ-033 Reset values: gnt=0, div_load=0, div_a=div_b=0, rsp_vld=0, rsp_id=0, rsp_q=rsp_r=0, rsp_err=0, counter=0, last-granted=1 (requester 0 priority).
REQ-034 After res deasserts, first grant no earlier than next rising edge with req sampled.

Verification
REQ-035 req=01, a0=13, b0=4; div_done 6 cycles after div_load with q=3,r=1 -> gnt=01 at T, div_load T+1, div_a=13,div_b=4, rsp_vld id=0 q=3 r=1 err=0.
REQ-036 req=11 held across three jobs from reset -> grant order 0,1,0; each rsp_id matches grant.
REQ-037 req=10, a1=0, b1=7 -> gnt=10, no div_load, rsp_vld at T+1 id=1 err=1 q=r=0.
REQ-038 div_done never asserted, TIMEOUT=15 -> rsp_vld after 15 WAIT cycles, err=1, q=r=0, FSM back to IDLE.
REQ-039 res pulsed during WAIT, then div_done -> all outputs at reset values, no rsp_vld, next req granted normally.
REQ-040 div_done pulsed in IDLE with req=00 -> no rsp_vld, no state change.
